// File: rtl/rv32_decode_ctrl.sv
// RV32 decode-stage controller: opcode classification, immediate-type select,
// a valid/ready register stage with a 2-entry skid buffer, flush and stall counting.
package rv32_decode_pkg;
    typedef logic [31:0] rv32_instr_t;

    typedef enum logic [2:0] {
        RV32_TYPE_I = 3'd0,
        RV32_TYPE_S = 3'd1,
        RV32_TYPE_B = 3'd2,
        RV32_TYPE_U = 3'd3,
        RV32_TYPE_J = 3'd4
    } rv32_type_enum_t;

    typedef struct packed {
        rv32_instr_t     instr;
        logic [31:0]     pc;
        rv32_type_enum_t imm_type;
        logic            uses_imm;
        logic            illegal;
    } rv32_entry_t;
endpackage

module rv32_decode_ctrl
    import rv32_decode_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   if_valid,
    output logic                   if_ready,
    input  rv32_instr_t            if_instr,
    input  logic [31:0]            if_pc,
    output logic                   id_valid,
    input  logic                   id_ready,
    output rv32_instr_t            id_instr,
    output logic [31:0]            id_pc,
    output rv32_type_enum_t        id_imm_type,
    output logic                   id_uses_imm,
    output logic                   id_illegal,
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

    // Handshake: a beat moves on any rising clk edge where valid && ready are both 1;
    // the producer holds valid and data stable until that edge, and ready never
    // depends combinationally on valid.
    rv32_entry_t main_ent, skid_ent, in_ent;
    logic        main_valid, skid_valid;
    logic        in_xfer, out_xfer;
    logic [STALL_CNT_W-1:0] stall_q;

    always_comb begin
        in_ent          = '0;
        in_ent.instr    = if_instr;
        in_ent.pc       = if_pc;
        in_ent.imm_type = RV32_TYPE_I;
        in_ent.uses_imm = 1'b1;
        in_ent.illegal  = 1'b0;
        case (if_instr[6:0])
            7'b0000011, 7'b0001111, 7'b0010011,
            7'b1100111, 7'b1110011:             in_ent.imm_type = RV32_TYPE_I;
            7'b0100011:                         in_ent.imm_type = RV32_TYPE_S;
            7'b1100011:                         in_ent.imm_type = RV32_TYPE_B;
            7'b0110111, 7'b0010111:             in_ent.imm_type = RV32_TYPE_U;
            7'b1101111:                         in_ent.imm_type = RV32_TYPE_J;
            7'b0110011:                         in_ent.uses_imm = 1'b0;
            // Opcodes with instr[1:0] != 2'b11 also land here.
            default: begin
                in_ent.uses_imm = 1'b0;
                in_ent.illegal  = 1'b1;
            end
        endcase
    end

    assign in_xfer  = if_valid && !skid_valid;
    assign out_xfer = main_valid && id_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid        <= 1'b0;
            skid_valid        <= 1'b0;
            main_ent          <= '0;
            main_ent.imm_type <= RV32_TYPE_I;
            skid_ent          <= '0;
            skid_ent.imm_type <= RV32_TYPE_I;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_xfer && skid_valid) begin
            main_ent   <= skid_ent;
            skid_valid <= 1'b0;
        end else if (in_xfer && (!main_valid || out_xfer)) begin
            main_ent   <= in_ent;
            main_valid <= 1'b1;
        end else if (in_xfer) begin
            skid_ent   <= in_ent;
            skid_valid <= 1'b1;
        end else if (out_xfer) begin
            main_valid <= 1'b0;
        end
    end

    // Flush does not clear the counter; it only suppresses counting on that edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (!flush && main_valid && !id_ready && stall_q != STALL_MAX) begin
            stall_q <= stall_q + STALL_CNT_W'(1);
        end
    end

    assign if_ready    = !skid_valid;
    assign id_valid    = main_valid;
    assign id_instr    = main_ent.instr;
    assign id_pc       = main_ent.pc;
    assign id_imm_type = main_ent.imm_type;
    assign id_uses_imm = main_ent.uses_imm;
    assign id_illegal  = main_ent.illegal;
    assign stall_cnt   = stall_q;
endmodule

// File: tb/tb_rv32_decode_ctrl.sv
// Randomized and directed bench for rv32_decode_ctrl against a queue-based
// reference model of a 2-deep in-order stage with opcode classification.
module tb_rv32_decode_ctrl;
    import rv32_decode_pkg::*;

    localparam int W = 4;
    localparam int STALL_SAT = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst, flush, if_valid, if_ready, id_valid, id_ready;
    logic id_uses_imm, id_illegal;
    rv32_instr_t if_instr, id_instr;
    logic [31:0] if_pc, id_pc;
    rv32_type_enum_t id_imm_type;
    logic [W-1:0] stall_cnt;

    rv32_decode_ctrl #(.STALL_CNT_W(W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
        .id_imm_type(id_imm_type), .id_uses_imm(id_uses_imm), .id_illegal(id_illegal),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Scoreboard: {pc, instr} of accepted instructions in delivery order.
    logic [63:0] exp_q[$];
    int exp_stall;
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // Classification straight from the opcode table.
    function automatic void ref_decode(input logic [31:0] ins, output logic [2:0] typ,
                                       output logic uses, output logic ill);
        typ = 3'd0; uses = 1'b1; ill = 1'b0;
        case (ins[6:0])
            7'h03, 7'h0f, 7'h13, 7'h67, 7'h73: typ = 3'd0;
            7'h23: typ = 3'd1;
            7'h63: typ = 3'd2;
            7'h37, 7'h17: typ = 3'd3;
            7'h6f: typ = 3'd4;
            7'h33: uses = 1'b0;
            default: begin uses = 1'b0; ill = 1'b1; end
        endcase
    endfunction

    function automatic logic [31:0] type_code(input rv32_type_enum_t t);
        case (t)
            RV32_TYPE_I: return 32'd0;
            RV32_TYPE_S: return 32'd1;
            RV32_TYPE_B: return 32'd2;
            RV32_TYPE_U: return 32'd3;
            RV32_TYPE_J: return 32'd4;
            default:     return 32'hffff_ffff;
        endcase
    endfunction

    task automatic model_edge();
        int occ;
        occ = exp_q.size();
        if (flush) begin
            exp_q.delete();
        end else begin
            if (occ > 0 && !id_ready && exp_stall < STALL_SAT) exp_stall++;
            if (occ > 0 && id_ready) void'(exp_q.pop_front());
            if (if_valid && occ < 2) exp_q.push_back({if_pc, if_instr});
        end
    endtask

    task automatic compare();
        logic [2:0] typ;
        logic uses, ill;
        check("id_valid", 32'(id_valid), 32'(exp_q.size() > 0));
        check("if_ready", 32'(if_ready), 32'(exp_q.size() < 2));
        check("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
        if (exp_q.size() > 0) begin
            ref_decode(exp_q[0][31:0], typ, uses, ill);
            check("id_instr", id_instr, exp_q[0][31:0]);
            check("id_pc", id_pc, exp_q[0][63:32]);
            check("id_imm_type", type_code(id_imm_type), 32'(typ));
            check("id_uses_imm", 32'(id_uses_imm), 32'(uses));
            check("id_illegal", 32'(id_illegal), 32'(ill));
        end
    endtask

    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic rdy, input logic fl);
        if_valid = v; if_instr = ins; if_pc = pc; id_ready = rdy; flush = fl;
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        exp_stall = 0;
    endtask

    logic [6:0] op_pool[14] = '{7'h03, 7'h0f, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63,
                                7'h37, 7'h17, 7'h6f, 7'h33, 7'h7f, 7'h00, 7'h5b};

    initial begin
        rst = 1'b1; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
        if_instr = '0; if_pc = '0;
        exp_stall = 0;
        #2;
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_if_ready", 32'(if_ready), 32'd1);
        check("rst_id_instr", id_instr, 32'd0);
        check("rst_id_pc", id_pc, 32'd0);
        check("rst_imm_type", type_code(id_imm_type), 32'd0);
        check("rst_uses_imm", 32'(id_uses_imm), 32'd0);
        check("rst_illegal", 32'(id_illegal), 32'd0);
        check("rst_stall", 32'(stall_cnt), 32'd0);
        do_reset();

        // Single addi, then a back-to-back stream of mixed formats.
        step(1, 32'h00500093, 32'h100, 1, 0);
        step(1, 32'h00112623, 32'h104, 1, 0);
        step(1, 32'h00208463, 32'h108, 1, 0);
        step(1, 32'h123452B7, 32'h10c, 1, 0);
        step(1, 32'h008000EF, 32'h110, 1, 0);
        step(1, 32'h002081B3, 32'h114, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0);

        // Back-pressure: three offered, two accepted, then drain.
        step(1, 32'h00a00113, 32'h200, 0, 0);
        step(1, 32'h00b00193, 32'h204, 0, 0);
        step(1, 32'h00c00213, 32'h208, 0, 0);
        step(1, 32'h00c00213, 32'h208, 0, 0);
        step(1, 32'h00c00213, 32'h208, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0);

        // Fill both entries, then flush with a new instruction offered.
        step(1, 32'h00d00293, 32'h300, 0, 0);
        step(1, 32'h00e00313, 32'h304, 0, 0);
        step(1, 32'h00f00393, 32'h308, 0, 1);
        step(0, 32'h0, 32'h0, 1, 0);

        // Illegal encodings still flow through.
        step(1, 32'hdeadbeff, 32'h400, 1, 0);
        step(1, 32'h00500090, 32'h404, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0);

        // Saturate the stall counter, then reset asynchronously mid-cycle.
        for (int i = 0; i < 20; i++) step(i == 0, 32'h00100013, 32'h500, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_id_valid", 32'(id_valid), 32'd0);
        check("async_rst_stall", 32'(stall_cnt), 32'd0);
        check("async_rst_if_ready", 32'(if_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        exp_stall = 0;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ins;
            ins = {$urandom_range(0, 32'h01ff_ffff), 7'h00};
            ins[6:0] = op_pool[$urandom_range(0, 13)];
            step($urandom_range(0, 3) != 0, ins, $urandom, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 19) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
